// File: rtl/spi_ahb_fifo_bridge.sv
// AHB-lite slave bridging the bus to a byte-level SPI master core through TX/RX FIFOs,
// with a STATUS register and a CTRL register for flushes, sticky-flag clear and rx_enable.
module spi_ahb_fifo_bridge #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic              hwrite,
    input  logic [31:0]       haddr,
    input  logic [31:0]       hwdata,
    output logic [31:0]       hrdata,
    input  logic [DATA_W-1:0] spi_data_out,
    input  logic              spi_busy,
    output logic [DATA_W-1:0] spi_data_in,
    output logic              spi_ready_send
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW-1:0] TX_PTR_ONE  = 1;
    localparam logic [RX_AW-1:0] RX_PTR_ONE  = 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;

    logic              dp_valid_q, dp_write_q;
    logic [15:0]       dp_addr_q;

    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr_q, tx_rptr_q;
    logic [TX_AW:0]    tx_cnt_q;
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wptr_q, rx_rptr_q;
    logic [RX_AW:0]    rx_cnt_q;

    logic              tx_ovf_q, rx_ovf_q, rx_unf_q, rx_en_q;
    logic [1:0]        state_q;
    logic [DATA_W-1:0] spi_data_in_q;
    logic              spi_ready_send_q;

    logic wr_tx, rd_rx, wr_ctrl, flush_tx, flush_rx, clr_flags;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_pop, tx_push, tx_ovf_set;
    logic xfer_done, rx_push_req, rx_pop, rx_push, rx_ovf_set, rx_unf_set;
    logic busy;
    logic [31:0] status;
    logic unused_bits;

    assign unused_bits = ^{haddr[31:16], hwdata};

    assign wr_tx     = dp_valid_q & dp_write_q & (dp_addr_q == 16'h0000);
    assign rd_rx     = dp_valid_q & ~dp_write_q & (dp_addr_q == 16'h0004);
    assign wr_ctrl   = dp_valid_q & dp_write_q & (dp_addr_q == 16'h000C);
    assign flush_tx  = wr_ctrl & hwdata[0];
    assign flush_rx  = wr_ctrl & hwdata[1];
    assign clr_flags = wr_ctrl & hwdata[2];

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    // A flush during REQ can leave the FIFO empty; the latched head still goes out.
    assign tx_pop     = (state_q == REQ) & spi_busy & ~tx_empty;
    assign tx_push    = wr_tx & (~tx_full | tx_pop);
    assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

    assign xfer_done   = (state_q == XFER) & ~spi_busy;
    assign rx_push_req = xfer_done & rx_en_q;
    assign rx_pop      = rd_rx & ~rx_empty;
    assign rx_unf_set  = rd_rx & rx_empty;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovf_set  = rx_push_req & rx_full & ~rx_pop;

    assign busy   = (state_q != IDLE) | spi_busy;
    assign status = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), rx_unf_q, rx_ovf_q, tx_ovf_q, busy,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 16'h0000;
        end else begin
            dp_valid_q <= hsel;
            if (hsel) begin
                dp_write_q <= hwrite;
                dp_addr_q  <= haddr[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= hwdata[DATA_W-1:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= spi_data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else if (flush_tx) begin
            tx_rptr_q <= tx_wptr_q;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TX_PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_PTR_ONE;
            tx_cnt_q <= tx_cnt_q + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
        end
    end

    // A flush wins over a word arriving from the SPI core on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else if (flush_rx) begin
            rx_rptr_q <= rx_wptr_q;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + RX_PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RX_PTR_ONE;
            rx_cnt_q <= rx_cnt_q + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
        end
    end

    // Sticky flags: a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            rx_en_q  <= 1'b1;
        end else begin
            tx_ovf_q <= (tx_ovf_q & ~clr_flags) | tx_ovf_set;
            rx_ovf_q <= (rx_ovf_q & ~clr_flags) | rx_ovf_set;
            rx_unf_q <= (rx_unf_q & ~clr_flags) | rx_unf_set;
            if (wr_ctrl) rx_en_q <= hwdata[3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            spi_data_in_q    <= '0;
            spi_ready_send_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (~tx_empty & ~spi_busy) begin
                        state_q          <= REQ;
                        spi_data_in_q    <= tx_mem_q[tx_rptr_q];
                        spi_ready_send_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (spi_busy) begin
                        state_q          <= XFER;
                        spi_ready_send_q <= 1'b0;
                    end
                end
                XFER: begin
                    if (~spi_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_data_in    = spi_data_in_q;
    assign spi_ready_send = spi_ready_send_q;

    always_comb begin
        hrdata = 32'h0000_0000;
        if (dp_valid_q & ~dp_write_q) begin
            case (dp_addr_q)
                16'h0004: if (~rx_empty) hrdata = 32'(rx_mem_q[rx_rptr_q]);
                16'h0008: hrdata = status;
                16'h000C: hrdata[3] = rx_en_q;
                default:  hrdata = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ahb_fifo_bridge.sv
// Bench for spi_ahb_fifo_bridge: directed register-map scenarios plus randomized bus/SPI traffic
// checked every cycle against a queue-based reference model.
module tb_spi_ahb_fifo_bridge;

    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hsel, hwrite;
    logic [31:0]       haddr, hwdata, hrdata;
    logic [DATA_W-1:0] spi_data_out, spi_data_in;
    logic              spi_busy, spi_ready_send;

    always #5 clk = ~clk;

    spi_ahb_fifo_bridge #(
        .DATA_W  (DATA_W),
        .TX_DEPTH(TX_DEPTH),
        .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hsel          (hsel),
        .hwrite        (hwrite),
        .haddr         (haddr),
        .hwdata        (hwdata),
        .hrdata        (hrdata),
        .spi_data_out  (spi_data_out),
        .spi_busy      (spi_busy),
        .spi_data_in   (spi_data_in),
        .spi_ready_send(spi_ready_send)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                m_dv, m_dw;
    logic [15:0]       m_da;
    logic [DATA_W-1:0] txq[$];
    logic [DATA_W-1:0] rxq[$];
    bit                m_tovf, m_rovf, m_runf, m_rx_en;
    int                m_phase;    // 0 waiting for work, 1 request posted, 2 word on the wire
    bit                m_ready;
    logic [DATA_W-1:0] m_din;
    bit                chk_en = 1'b0;

    function automatic logic [31:0] exp_hrdata();
        logic [31:0] st;
        if (!m_dv || m_dw) return 32'h0;
        case (m_da)
            16'h0004: return (rxq.size() > 0) ? 32'(rxq[0]) : 32'h0;
            16'h0008: begin
                st = 32'h0;
                st[0]     = (txq.size() == TX_DEPTH);
                st[1]     = (txq.size() == 0);
                st[2]     = (rxq.size() == RX_DEPTH);
                st[3]     = (rxq.size() == 0);
                st[4]     = (m_phase != 0) || spi_busy;
                st[5]     = m_tovf;
                st[6]     = m_rovf;
                st[7]     = m_runf;
                st[15:8]  = 8'(txq.size());
                st[23:16] = 8'(rxq.size());
                return st;
            end
            16'h000C: return m_rx_en ? 32'h8 : 32'h0;
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit wr_tx, rd_rx, wr_ctrl, start, taken, done;
        if (rst) begin
            m_dv = 0; m_dw = 0; m_da = '0;
            txq.delete(); rxq.delete();
            m_tovf = 0; m_rovf = 0; m_runf = 0; m_rx_en = 1;
            m_phase = 0; m_ready = 0; m_din = '0;
        end else begin
            wr_tx   = m_dv && m_dw && m_da == 16'h0000;
            rd_rx   = m_dv && !m_dw && m_da == 16'h0004;
            wr_ctrl = m_dv && m_dw && m_da == 16'h000C;
            start   = (m_phase == 0) && txq.size() > 0 && !spi_busy;
            taken   = (m_phase == 1) && spi_busy;
            done    = (m_phase == 2) && !spi_busy;
            if (wr_ctrl && hwdata[2]) begin m_tovf = 0; m_rovf = 0; m_runf = 0; end
            if (start) begin m_din = txq[0]; m_ready = 1; m_phase = 1; end
            if (taken) begin
                m_ready = 0; m_phase = 2;
                if (txq.size() > 0) void'(txq.pop_front());
            end
            if (wr_tx) begin
                if (txq.size() < TX_DEPTH) txq.push_back(hwdata[DATA_W-1:0]);
                else m_tovf = 1;
            end
            if (rd_rx) begin
                if (rxq.size() > 0) void'(rxq.pop_front());
                else m_runf = 1;
            end
            if (done) begin
                m_phase = 0;
                if (m_rx_en) begin
                    if (rxq.size() < RX_DEPTH) rxq.push_back(spi_data_out);
                    else m_rovf = 1;
                end
            end
            if (wr_ctrl) begin
                if (hwdata[0]) txq.delete();
                if (hwdata[1]) rxq.delete();
                m_rx_en = hwdata[3];
            end
            m_dv = hsel; 
            if (hsel) begin m_dw = hwrite; m_da = haddr[15:0]; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hrdata", hrdata, exp_hrdata());
            check("spi_ready_send", 32'(spi_ready_send), 32'(m_ready));
            check("spi_data_in", 32'(spi_data_in), 32'(m_din));
        end
    end

    // Records the word presented at each rising edge of the request.
    logic [DATA_W-1:0] sent_q[$];
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (spi_ready_send && !prev_ready) sent_q.push_back(spi_data_in);
        prev_ready = spi_ready_send;
    end

    // ---------------- SPI master stand-in ----------------
    bit                sl_hold = 1'b0;
    int                sl_len  = 0;    // 0 = random length and random start delay
    int                sl_left = 0;
    logic [DATA_W-1:0] sl_data_q[$];

    initial begin
        spi_busy     = 1'b0;
        spi_data_out = '0;
        forever begin
            @(posedge clk); #1;
            if (sl_hold) begin
                spi_busy = 1'b1;
            end else if (sl_left > 0) begin
                sl_left--;
                if (sl_left == 0) spi_busy = 1'b0;
            end else begin
                spi_busy = 1'b0;
                if (spi_ready_send && (sl_len != 0 || $urandom_range(1) == 1)) begin
                    spi_busy     = 1'b1;
                    sl_left      = (sl_len != 0) ? sl_len : int'($urandom_range(4, 1));
                    spi_data_out = (sl_data_q.size() > 0) ? sl_data_q.pop_front()
                                                          : DATA_W'($urandom);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        hsel = 1; hwrite = 1; haddr = a;
        tick();
        hsel = 0; hwdata = d;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        hsel = 1; hwrite = 0; haddr = a;
        tick();
        hsel = 0;
        @(negedge clk);
        d = hrdata;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(m_phase == 0 && txq.size() == 0 && !spi_busy) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", 32'(n >= budget), 32'h0);
        tick();
    endtask

    initial begin
        logic [31:0] d;
        bit prev_ctrl;
        int n;
        hsel = 0; hwrite = 0; haddr = '0; hwdata = '0;
        repeat (3) tick();
        rst = 0;
        chk_en = 1;

        // Reset state
        check("reset_ready", 32'(spi_ready_send), 32'h0);
        check("reset_data_in", 32'(spi_data_in), 32'h0);
        bus_read(32'h8, d); check("reset_status", d, 32'h0000_000A);
        bus_read(32'hC, d); check("reset_ctrl", d, 32'h0000_0008);

        // Two words out, two words back
        sl_len = 4;
        sl_data_q = '{8'h11, 8'h22};
        sent_q.delete();
        bus_write(32'h0, 32'hA5);
        bus_write(32'h0, 32'h3C);
        wait_idle(200);
        check("ready_pulses", 32'(sent_q.size()), 32'd2);
        if (sent_q.size() == 2) begin
            check("sent0", 32'(sent_q[0]), 32'hA5);
            check("sent1", 32'(sent_q[1]), 32'h3C);
        end
        bus_read(32'h4, d); check("rx0", d, 32'h11);
        bus_read(32'h4, d); check("rx1", d, 32'h22);
        bus_read(32'h8, d); check("status_after_rx", d, 32'h0000_000A);

        // TX overflow while the SPI core is held busy (TX_DEPTH = 4)
        sl_hold = 1;
        repeat (2) tick();
        for (int i = 0; i <= TX_DEPTH; i++) bus_write(32'h0, 32'h50 + 32'(i));
        bus_read(32'h8, d); check("tx_overflow_status", d, 32'h0000_0439);
        bus_write(32'hC, 32'h4);
        bus_read(32'h8, d); check("tx_overflow_cleared", d, 32'h0000_0419);
        bus_write(32'hC, 32'h9);
        sl_hold = 0;
        repeat (3) tick();
        bus_read(32'h8, d); check("after_tx_flush", d, 32'h0000_000A);
        bus_read(32'hC, d); check("ctrl_rx_en_back", d, 32'h0000_0008);

        // RX underflow
        bus_read(32'h4, d); check("rx_empty_read", d, 32'h0);
        bus_read(32'h8, d); check("rx_underflow_status", d, 32'h0000_008A);
        bus_write(32'hC, 32'hC);
        bus_read(32'h8, d); check("flags_cleared", d, 32'h0000_000A);

        // rx_enable=0 discards received words
        bus_write(32'hC, 32'h0);
        sl_len = 2;
        for (int i = 0; i < 3; i++) bus_write(32'h0, 32'h70 + 32'(i));
        wait_idle(300);
        bus_read(32'h8, d); check("rx_disabled_status", d, 32'h0000_000A);
        bus_read(32'hC, d); check("ctrl_rx_en_off", d, 32'h0);
        bus_write(32'hC, 32'h8);

        // RX overflow (RX_DEPTH = 4): fifth word dropped
        sl_data_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        for (int i = 0; i <= RX_DEPTH; i++) begin
            bus_write(32'h0, 32'h60 + 32'(i));
            wait_idle(100);
        end
        bus_read(32'h8, d); check("rx_overflow_status", d, 32'h0004_0046);
        for (int i = 0; i < RX_DEPTH; i++) begin
            bus_read(32'h4, d); check("rx_preserved", d, 32'h31 + 32'(i));
        end
        bus_read(32'h8, d); check("rx_drained_status", d, 32'h0000_004A);
        bus_write(32'hC, 32'hC);

        // Reset in the middle of a transfer with two words still queued
        sl_hold = 1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) bus_write(32'h0, 32'h80 + 32'(i));
        sl_len = 6;
        sl_hold = 0;
        n = 0;
        while (spi_ready_send == 0 && n < 50) begin tick(); n++; end
        while (spi_busy == 0 && n < 50) begin tick(); n++; end
        check("xfer_start_timeout", 32'(n >= 50), 32'h0);
        tick();
        bus_read(32'h8, d); check("mid_xfer_status", d, 32'h0000_0218);
        rst = 1;
        tick();
        rst = 0;
        check("ready_after_reset", 32'(spi_ready_send), 32'h0);
        n = 0;
        while (spi_busy && n < 20) begin tick(); n++; end
        check("busy_fall_timeout", 32'(n >= 20), 32'h0);
        repeat (20) begin
            tick();
            check("no_req_after_reset", 32'(spi_ready_send), 32'h0);
        end
        bus_read(32'h8, d); check("status_after_reset", d, 32'h0000_000A);

        // Randomized traffic
        sl_len = 0;
        prev_ctrl = 0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            hwdata = $urandom;
            if (prev_ctrl) begin
                hwdata[3] = ($urandom_range(7) != 0);
                if ($urandom_range(3) != 0) hwdata[2:0] = 3'b000;
            end
            hsel   = ($urandom_range(3) != 0);
            hwrite = $urandom_range(1);
            r = int'($urandom_range(15));
            haddr[31:16] = 16'($urandom);
            haddr[15:0]  = (r < 5) ? 16'h0000 : (r < 9) ? 16'h0004 : (r < 12) ? 16'h0008 :
                           (r < 14) ? 16'h000C : (r == 14) ? 16'h0010 : 16'h0006;
            prev_ctrl = hsel && hwrite && haddr[15:0] == 16'h000C;
            rst = ($urandom_range(999) == 0);
            tick();
        end
        rst = 0;
        hsel = 0;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ahb_fifo_bridge.md
# spi_ahb_fifo_bridge

Parametrised AHB-lite slave bridging the bus to the byte-level SPI master core, replacing the single-register connector with TX and RX FIFOs, a status register and a control register. Software queues up to TX_DEPTH words without polling between transfers; received words are buffered in an RX FIFO and popped by bus reads. Sits between the AHB interconnect (selected by hsel) and the SPI master's spi_data_in/spi_ready_send/spi_busy/spi_data_out handshake.

## Interface
- DATA_W, 8: SPI word width, 1..16.
- TX_DEPTH, 4: TX FIFO entries, power of two, 2..128.
- RX_DEPTH, 4: RX FIFO entries, power of two, 2..128.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- hsel  in  1  slave select (address phase).
- hwrite  in  1  1 = write, 0 = read (address phase).
- haddr  in  32  byte address; only haddr[15:0] decoded.
- hwdata  in  32  write data (data phase).
- hrdata  out  32  read data (data phase).
- spi_data_out  in  DATA_W  word received by SPI master, valid when spi_busy falls.
- spi_busy  in  1  SPI master transferring.
- spi_data_in  out  DATA_W  word to transmit.
- spi_ready_send  out  1  request: spi_data_in valid, start transfer.

## Operation
- Register map (haddr[15:0]): 0x0000 TXDATA (W: push hwdata[DATA_W-1:0]); 0x0004 RXDATA (R: pop, zero-extended); 0x0008 STATUS (R); 0x000C CTRL (R/W). Other offsets: writes ignored, reads return 0.
- Bus: address phase registered when hsel=1 (addr, write flag, valid). Action happens in following cycle (data phase) using hwdata; no wait states.
- STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] busy (tx state != IDLE or spi_busy), [5] tx_overflow, [6] rx_overflow, [7] rx_underflow, [15:8] tx_count, [23:16] rx_count, rest 0. Bits 5-7 sticky.
- CTRL write: [0] flush TX FIFO, [1] flush RX FIFO, [2] clear sticky flags (bits 0-2 self-clearing, read 0); [3] rx_enable, stored, reset 1. CTRL read returns {28'b0, rx_enable, 3'b0}.
- TXDATA write when tx_full: dropped, tx_overflow set. Push when full accepted if TX pop occurs same cycle.
- RXDATA read when rx_empty: returns 0, no pop, rx_underflow set.
- TX state machine: IDLE -> REQ when TX FIFO non-empty and spi_busy=0 (spi_data_in <= head, spi_ready_send <= 1). REQ -> XFER when spi_busy sampled 1 (spi_ready_send <= 0, pop head). XFER -> IDLE when spi_busy sampled 0; on that edge push spi_data_out into RX FIFO if rx_enable=1.
- RX push when rx_full: word dropped, rx_overflow set; push when full accepted if RXDATA pop same cycle.
- TX flush while in REQ/XFER: current transfer completes normally (head already latched); remaining entries discarded.
- spi_data_in holds last sent word while idle.

## Timing
- Reset: hrdata 0, spi_data_in 0, spi_ready_send 0, FIFOs empty, sticky flags 0, rx_enable 1, state IDLE, pending address phase cleared.
- TXDATA write address phase at cycle N, data phase N+1, entry visible cycle N+2; with TX idle, spi_ready_send=1 at N+3 edge output (one cycle after push).
- spi_ready_send deasserts the cycle after spi_busy first sampled high; next REQ no earlier than one cycle after spi_busy sampled low.
- RX word readable via RXDATA starting the cycle after the busy-fall edge; STATUS counts update same edge.
- hrdata registered-free: combinational from data-phase address and current state; RXDATA pop at end of data phase.
- Back-to-back bus transfers allowed every cycle; address phase of next transfer overlaps data phase of current.

## Test plan
- Reset then STATUS read -> 0x0000_000A (tx_empty, rx_empty), CTRL read -> 0x8.
- Write 0xA5, 0x3C to TXDATA, SPI model busy 4 cycles returning 0x11, 0x22 -> spi_data_in 0xA5 then 0x3C with one ready pulse each; RXDATA reads 0x11, 0x22, then STATUS rx_empty=1.
- Hold spi_busy=1, write TX_DEPTH+1 words -> tx_full=1, tx_count=TX_DEPTH, tx_overflow=1; CTRL write 0x4 -> bit 5 cleared.
- Read RXDATA when empty -> hrdata 0, rx_underflow=1, rx_count unchanged.
- rx_enable=0 (CTRL 0x0), send 3 words -> rx_count stays 0; RX_DEPTH+1 transfers with rx_enable=1 and no reads -> rx_overflow=1, first RX_DEPTH words preserved.
- Assert rst during XFER with 2 words queued -> next cycle spi_ready_send 0, STATUS 0x0000_000A, no further requests after spi_busy falls.
